// File: rtl/prog_loader.sv
// Program loader: streams host instruction words into instruction memory, then
// launches the core and times its run until the PC hits a halt address or a cycle limit.
module prog_loader #(
    parameter int INSTR_W      = 9,
    parameter int ADDR_W       = 8,
    parameter int START_CYCLES = 2,
    parameter int MAX_CYCLES   = 65535
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               Begin,
    input  logic [ADDR_W-1:0]  BaseAddr,
    input  logic [ADDR_W:0]    Len,
    input  logic [ADDR_W-1:0]  LaunchAddr,
    input  logic [ADDR_W-1:0]  HaltPC,
    input  logic               InValid,
    input  logic [INSTR_W-1:0] InData,
    output logic               InReady,
    output logic               WrEn,
    output logic [ADDR_W-1:0]  WrAddr,
    output logic [INSTR_W-1:0] WrData,
    input  logic [ADDR_W-1:0]  PC,
    output logic               Start,
    output logic [ADDR_W-1:0]  Start_Addr,
    output logic               Busy,
    output logic               Done,
    output logic               Timeout,
    output logic [15:0]        CycleCount
);

    localparam int SC_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, START, RUN, DONE} state_t;

    state_t            state, nextState;
    logic [ADDR_W-1:0] baseReg, haltReg;
    logic [ADDR_W:0]   lenReg, idx;
    logic [SC_W-1:0]   startCnt;
    logic [15:0]       cntNext;
    logic              beginOk, xfer, lastWord, startLast, haltHit, timeHit;

    assign beginOk   = Begin && (state == IDLE || state == DONE);
    assign xfer      = InValid && InReady;
    assign lastWord  = xfer && ((idx + 1'b1) == lenReg);
    assign startLast = (startCnt == SC_W'(START_CYCLES - 1));
    assign cntNext   = (CycleCount == 16'hFFFF) ? CycleCount : CycleCount + 16'd1;
    assign haltHit   = (PC == haltReg);
    // Limit is checked against the count including the current cycle.
    assign timeHit   = (cntNext >= 16'(MAX_CYCLES));

    always_ff @(posedge CLK) begin
        if (Reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        InReady   = 1'b0;
        Start     = 1'b0;
        Busy      = 1'b0;
        Done      = 1'b0;
        case (state)
            IDLE, DONE: begin
                Done = (state == DONE);
                if (Begin) nextState = (Len == '0) ? START : LOAD;
            end
            LOAD: begin
                InReady = 1'b1;
                Busy    = 1'b1;
                if (lastWord) nextState = START;
            end
            START: begin
                Start = 1'b1;
                Busy  = 1'b1;
                if (startLast) nextState = RUN;
            end
            RUN: begin
                Busy = 1'b1;
                if (haltHit || timeHit) nextState = DONE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            baseReg    <= '0;
            haltReg    <= '0;
            lenReg     <= '0;
            idx        <= '0;
            startCnt   <= '0;
            WrEn       <= 1'b0;
            WrAddr     <= '0;
            WrData     <= '0;
            Start_Addr <= '0;
            Timeout    <= 1'b0;
            CycleCount <= '0;
        end else begin
            WrEn <= 1'b0;
            if (beginOk) begin
                baseReg    <= BaseAddr;
                lenReg     <= Len;
                haltReg    <= HaltPC;
                Start_Addr <= LaunchAddr;
                idx        <= '0;
                Timeout    <= 1'b0;
            end
            if (state == LOAD && xfer) begin
                WrEn   <= 1'b1;
                WrAddr <= baseReg + idx[ADDR_W-1:0];
                WrData <= InData;
                idx    <= idx + 1'b1;
            end
            if (nextState == START && state != START) begin
                startCnt   <= '0;
                CycleCount <= '0;
            end else if (state == START) begin
                startCnt <= startCnt + 1'b1;
            end
            // Halt takes priority over timeout in the same cycle.
            if (state == RUN) begin
                CycleCount <= cntNext;
                if (!haltHit && timeHit) Timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: stimulus pushes expected writes, start bursts
// and completions into queues; a negedge monitor pops and compares them.
module tb_prog_loader;

    logic       CLK = 1'b0;
    logic       Reset, Begin, InValid;
    logic [7:0] BaseAddr, LaunchAddr, HaltPC, PC;
    logic [8:0] Len, InData;
    logic       InReady, WrEn, Start, Busy, Done, Timeout;
    logic [7:0] WrAddr, Start_Addr;
    logic [8:0] WrData;
    logic [15:0] CycleCount;

    prog_loader #(.INSTR_W(9), .ADDR_W(8), .START_CYCLES(2), .MAX_CYCLES(20)) dut (
        .CLK(CLK), .Reset(Reset), .Begin(Begin), .BaseAddr(BaseAddr), .Len(Len),
        .LaunchAddr(LaunchAddr), .HaltPC(HaltPC), .InValid(InValid), .InData(InData),
        .InReady(InReady), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .PC(PC),
        .Start(Start), .Start_Addr(Start_Addr), .Busy(Busy), .Done(Done),
        .Timeout(Timeout), .CycleCount(CycleCount)
    );

    always #5 CLK = ~CLK;

    // Core model: PC loads on Start, then advances one per cycle.
    always @(posedge CLK) begin
        if (Start) PC <= Start_Addr;
        else       PC <= PC + 8'd1;
    end

    int passCnt = 0;
    int totalCnt = 0;

    logic [16:0] wrQ[$];
    logic [7:0]  stQ[$];
    logic [16:0] dnQ[$];
    logic [8:0]  wbuf[0:7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    // Monitor
    int   stLen = 0;
    logic prevDone = 1'b0;
    always @(negedge CLK) begin
        if (WrEn) begin
            if (wrQ.size() == 0) chk("unexpected_write", {WrAddr, WrData}, 17'h0);
            else chk("write_addr_data", {WrAddr, WrData}, wrQ.pop_front());
        end
        if (Start) begin
            if (stQ.size() == 0) chk("unexpected_start", 32'(Start_Addr), 32'hFFFF);
            else chk("start_addr", 32'(Start_Addr), 32'(stQ[0]));
            stLen++;
        end else if (stLen > 0) begin
            chk("start_len", stLen, 2);
            if (stQ.size() > 0) void'(stQ.pop_front());
            stLen = 0;
        end
        if (Done && !prevDone) begin
            chk("done_busy", 32'(Busy), 0);
            if (dnQ.size() == 0) chk("unexpected_done", {Timeout, CycleCount}, 17'h0);
            else chk("done_timeout_count", {Timeout, CycleCount}, dnQ.pop_front());
        end
        prevDone = Done;
    end

    task automatic step();
        @(posedge CLK); #1;
    endtask

    task automatic doBegin(input logic [7:0] b, input logic [8:0] l, input logic [7:0] la, input logic [7:0] h);
        BaseAddr = b; Len = l; LaunchAddr = la; HaltPC = h; Begin = 1'b1;
        step();
        Begin = 1'b0;
        BaseAddr = 8'hAA; Len = 9'd7; LaunchAddr = 8'h99; HaltPC = 8'h77;
    endtask

    task automatic send(input int n, input logic [31:0] vpat);
        int k = 0;
        int cyc = 0;
        while (k < n && cyc < 64) begin
            InValid = (cyc < 32) ? vpat[cyc] : 1'b1;
            InData  = wbuf[k];
            chk("inready_load", 32'(InReady), 1);
            if (InValid && InReady) k++;
            step();
            cyc++;
        end
        InValid = 1'b0;
        if (k < n) chk("send_bound", k, n);
    endtask

    task automatic waitDone(input int maxc);
        int c = 0;
        while (!Done && c < maxc) begin step(); c++; end
        chk("done_wait", 32'(Done), 1);
    endtask

    initial begin
        Reset = 1'b1; Begin = 1'b0; InValid = 1'b0; InData = '0;
        BaseAddr = '0; Len = '0; LaunchAddr = '0; HaltPC = '0;
        step(); step();
        chk("reset_outputs", {InReady, WrEn, WrAddr, WrData, Start, Start_Addr, Busy, Done, Timeout, CycleCount}, '0);
        Reset = 1'b0;
        step();

        // Basic load and halt
        wbuf[0] = 9'h1A5; wbuf[1] = 9'h0C3; wbuf[2] = 9'h100;
        wrQ.push_back({8'h10, 9'h1A5}); wrQ.push_back({8'h11, 9'h0C3}); wrQ.push_back({8'h12, 9'h100});
        stQ.push_back(8'h10); dnQ.push_back({1'b0, 16'd3});
        doBegin(8'h10, 9'd3, 8'h10, 8'h12);
        send(3, 32'hFFFFFFFF);
        waitDone(50);
        chk("hold_start_addr", 32'(Start_Addr), 32'h10);

        // Address wrap
        wbuf[0] = 9'h001; wbuf[1] = 9'h002; wbuf[2] = 9'h0FF; wbuf[3] = 9'h1FF;
        wrQ.push_back({8'hFE, 9'h001}); wrQ.push_back({8'hFF, 9'h002});
        wrQ.push_back({8'h00, 9'h0FF}); wrQ.push_back({8'h01, 9'h1FF});
        stQ.push_back(8'h20); dnQ.push_back({1'b0, 16'd2});
        doBegin(8'hFE, 9'd4, 8'h20, 8'h21);
        send(4, 32'hFFFFFFFF);
        waitDone(50);

        // Gapped stream
        wbuf[0] = 9'h0A1; wbuf[1] = 9'h0B2; wbuf[2] = 9'h0C3;
        wrQ.push_back({8'h30, 9'h0A1}); wrQ.push_back({8'h31, 9'h0B2}); wrQ.push_back({8'h32, 9'h0C3});
        stQ.push_back(8'h30); dnQ.push_back({1'b0, 16'd1});
        doBegin(8'h30, 9'd3, 8'h30, 8'h30);
        send(3, 32'b11001);
        chk("inready_after_last", 32'(InReady), 0);
        waitDone(50);

        // Zero-length load
        stQ.push_back(8'h40); dnQ.push_back({1'b0, 16'd3});
        doBegin(8'h00, 9'd0, 8'h40, 8'h42);
        chk("len0_start_next", 32'(Start), 1);
        waitDone(50);

        // Timeout, then restart from DONE with a Begin during RUN
        wbuf[0] = 9'h055;
        wrQ.push_back({8'h50, 9'h055});
        stQ.push_back(8'h40); dnQ.push_back({1'b1, 16'd20});
        doBegin(8'h50, 9'd1, 8'h40, 8'h05);
        send(1, 32'hFFFFFFFF);
        waitDone(100);
        chk("timeout_flag", 32'(Timeout), 1);
        wbuf[0] = 9'h111; wbuf[1] = 9'h122;
        wrQ.push_back({8'h60, 9'h111}); wrQ.push_back({8'h61, 9'h122});
        stQ.push_back(8'h60); dnQ.push_back({1'b0, 16'd4});
        doBegin(8'h60, 9'd2, 8'h60, 8'h63);
        chk("restart_done_clear", {Done, InReady}, 2'b01);
        send(2, 32'hFFFFFFFF);
        for (int c = 0; c < 10 && Start; c++) step();
        chk("in_run", {Busy, Start}, 2'b10);
        BaseAddr = 8'h00; Len = 9'd0; LaunchAddr = 8'h11; HaltPC = 8'h11; Begin = 1'b1;
        step();
        Begin = 1'b0;
        chk("begin_ignored_run", {Busy, Start, InReady}, 3'b100);
        waitDone(50);

        // Reset mid-load
        wbuf[0] = 9'h0AB;
        wrQ.push_back({8'h70, 9'h0AB});
        doBegin(8'h70, 9'd3, 8'h70, 8'h72);
        send(1, 32'hFFFFFFFF);
        Reset = 1'b1;
        step();
        chk("midload_reset_outputs", {InReady, WrEn, WrAddr, WrData, Start, Start_Addr, Busy, Done, Timeout, CycleCount}, '0);
        Reset = 1'b0; InValid = 1'b1; InData = 9'h1EE;
        for (int c = 0; c < 4; c++) step();
        InValid = 1'b0;
        chk("post_reset_idle", {InReady, Busy, Done}, 3'b000);

        step(); step();
        chk("queues_drained", {16'(wrQ.size()), 8'(stQ.size()), 8'(dnQ.size())}, 32'h0);
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
